// File: rtl/gcd_pkg.sv
// Shared definitions for the binary (Stein) GCD engine.
// Holds the FSM state encoding and the shift-count width helper.
// The state encoding is kept here so that an ISE decoder can interpret
// busy/done and the engine state the same way the core does.
package gcd_pkg;

  // 3-bit encoding, fixed so external decode stays stable across builds
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_STRIP = 3'd2,
    ST_ODDA  = 3'd3,
    ST_LOOP  = 3'd4,
    ST_FIN   = 3'd5
  } gcd_state_e;

  // Width of the common power-of-two counter k (K_W = $clog2(WIDTH)+1)
  function automatic int gcd_k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_step_dp.sv
// Combinational step datapath for the Stein GCD engine.
// Produces the one-bit right-shifted operands, the a>b compare and both
// unsigned differences; the core picks which of these to register.
module gcd_step_dp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_half,
  output logic [WIDTH-1:0] b_half,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] a_minus_b,
  output logic [WIDTH-1:0] b_minus_a
);

  // Halving, compare and subtract; only the non-negative difference is ever used
  always_comb begin
    a_half    = a >> 1;
    b_half    = b >> 1;
    a_gt_b    = (a > b);
    a_minus_b = a - b;
    b_minus_a = b - a;
  end

endmodule

// File: rtl/gcd_stein_core.sv
// Iterative binary (Stein) GCD engine, one reduction step per clock.
// Operands are loaded with start while idle; done pulses for one cycle when
// result is valid and result is held until the next accepted start.
// Optional build macro GCD_CYCLE_COUNT_EN adds a 16-bit saturating busy-cycle
// counter on output port cycles.
//
// state | meaning
// IDLE  | waiting for start, result held
// CHECK | zero-operand shortcut
// STRIP | remove common factors of two into k
// ODDA  | make a odd
// LOOP  | subtract/halve until b is zero
// FIN   | done pulse, busy drops at end of cycle
module gcd_stein_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam int K_W = gcd_k_width(WIDTH);
  localparam logic [K_W-1:0] K_ONE = K_W'(1);

  gcd_state_e     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_a_half;
  logic [WIDTH-1:0] w_b_half;
  logic             w_a_gt_b;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;
  logic             w_accept;

  gcd_step_dp #(.WIDTH(WIDTH)) u_step_dp (
    .a         (r_a),
    .b         (r_b),
    .a_half    (w_a_half),
    .b_half    (w_b_half),
    .a_gt_b    (w_a_gt_b),
    .a_minus_b (w_a_minus_b),
    .b_minus_a (w_b_minus_a)
  );

  assign w_accept = (r_state == ST_IDLE) && start;

  // Engine FSM and operand registers; done is registered so it is a clean pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((r_a == '0) || (r_b == '0)) begin
            r_result <= r_a | r_b;
            r_done   <= 1'b1;
            r_state  <= ST_FIN;
          end else begin
            r_state <= ST_STRIP;
          end
        end
        ST_STRIP: begin
          if (!r_a[0] && !r_b[0]) begin
            r_a <= w_a_half;
            r_b <= w_b_half;
            r_k <= r_k + K_ONE;
          end else begin
            r_state <= ST_ODDA;
          end
        end
        ST_ODDA: begin
          if (!r_a[0]) begin
            r_a <= w_a_half;
          end else begin
            r_state <= ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (r_b == '0) begin
            r_result <= r_a << r_k;
            r_done   <= 1'b1;
            r_state  <= ST_FIN;
          end else if (!r_b[0]) begin
            r_b <= w_b_half;
          end else if (w_a_gt_b) begin
            // keep a as the smaller odd value so it stays odd
            r_a <= r_b;
            r_b <= w_a_minus_b;
          end else begin
            r_b <= w_b_minus_a;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  // Busy-cycle counter; the start cycle counts as the first cycle, saturates, holds after done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= 16'd0;
    end else if (w_accept) begin
      r_cycles <= 16'd1;
    end else if (r_busy && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 16'd1;
    end
  end

  assign cycles = r_cycles;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // w_accept only feeds the optional counter in the default build
  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_gcd_stein_core.sv
// Self-checking bench for gcd_stein_core: directed corner cases, protocol
// checks and randomized operands against a Euclid-based reference model.
module tb_gcd_stein_core;

  localparam int WIDTH = 32;
  localparam int MAX_LAT = 3 * WIDTH + 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0]      cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gcd_stein_core #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Euclid by remainder: independent of the binary algorithm in the DUT
  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Present operands for one cycle; returns at the negedge after the accepting edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the done pulse; lat counts cycles from the start cycle to the done cycle inclusive
  task automatic wait_done(output logic [31:0] res, output int lat, output bit ok);
    int n;
    n  = 1;
    ok = 1'b0;
    while (n <= 400) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    res = result;
    lat = n + 1;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int lat;
    bit ok;
    start_op(a, b);
    wait_done(res, lat, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_result"}, res, ref_gcd(a, b));
    chk({tag, "_lat_bound"}, 32'(lat <= MAX_LAT), 32'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_busy_low_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] ra;
    logic [31:0] rb;
    int lat;
    bit ok;
    int seen;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    run_and_check("g48_18", 32'd48, 32'd18);
    chk("g48_18_value", result, 32'd6);
    run_and_check("g0_7", 32'd0, 32'd7);
    chk("g0_7_value", result, 32'd7);
    run_and_check("g9_0", 32'd9, 32'd0);
    chk("g9_0_value", result, 32'd9);
    run_and_check("g_pow2", 32'h8000_0000, 32'h4000_0000);
    chk("g_pow2_value", result, 32'h4000_0000);
    run_and_check("g17_17", 32'd17, 32'd17);
    chk("g17_17_value", result, 32'd17);

    // zero/zero: minimum latency
    start_op(32'd0, 32'd0);
    wait_done(res, lat, ok);
    chk("g0_0_done", 32'(ok), 32'd1);
    chk("g0_0_result", res, 32'd0);
    chk("g0_0_latency", 32'(lat), 32'd3);
`ifdef GCD_CYCLE_COUNT_EN
    @(negedge clk);
    chk("cycles_at_done", 32'(cycles), 32'd3);
    repeat (3) @(negedge clk);
    chk("cycles_held", 32'(cycles), 32'd3);
`else
    @(negedge clk);
`endif

    // result held while idle
    run_and_check("hold_setup", 32'd84, 32'd36);
    repeat (4) @(negedge clk);
    chk("result_held_idle", result, 32'd12);

    // start while busy is ignored
    start_op(32'd48, 32'd18);
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'd5;
    b_in  = 32'd10;
    @(negedge clk);
    start = 1'b0;
    wait_done(res, lat, ok);
    chk("busy_ignore_done", 32'(ok), 32'd1);
    chk("busy_ignore_result", res, 32'd6);
    @(negedge clk);

    // reset in the middle of an operation
    start_op(32'd1071, 32'd462);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_and_check("post_rst", 32'd1071, 32'd462);
    chk("post_rst_value", result, 32'd21);

    // randomized operands, some sharing large power-of-two factors, some zero
    for (int i = 0; i < 40; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ((i % 4) == 1) begin
        ra = ra << $urandom_range(0, 12);
        rb = rb << $urandom_range(0, 12);
      end
      if ((i % 13) == 5) ra = 32'd0;
      run_and_check("rand", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
